// File: rtl/gcd_pkg.sv
// Shared definitions for the streaming binary-GCD engine.
// Contents: FSM state encoding, counter-width helper and the worst-case
// iteration bound used by both the engine and its bench.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMON = 2'd1,
    REDUCE = 2'd2,
    OUT    = 2'd3
  } state_e;

  // Width of the iteration counter. It leaves headroom above the worst case,
  // so the counter never wraps.
  function automatic int cycle_w(input int width);
    return $clog2(4 * width + 8);
  endfunction

  // Upper bound on edges spent in COMMON+REDUCE for one operand pair.
  function automatic int MAX_CYCLES(input int width);
    return 4 * width + 4;
  endfunction

endpackage

// File: rtl/gcd_fifo.sv
// Operand-pair queue: circular buffer with wrapping pointers and an occupancy count.
// Ports: clk/rst (async active-high), push_i/wdata_i write side, pop_i/rdata_o
//        read side (rdata_o shows the head combinationally), full_o/empty_o status.
module gcd_fifo #(
  parameter int WIDTH2 = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH2-1:0] wdata_i,
  input  logic              pop_i,
  output logic [WIDTH2-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH2-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  // Guard against overflow/underflow here as well, so a misbehaving caller
  // cannot corrupt the pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD engine with an input queue, one shift or subtract per clock.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_a/in_b operand side;
//        out_valid/out_ready/out_result/out_a/out_b/out_cycles result side.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = cycle_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CW-1:0]    out_cycles
);

  localparam int KW = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cyc_q, cyc_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               head_zero;
  logic               push;
  logic               pop;
  logic               both_even;

  // ---------------------------------------------------------------- queue
  // in_ready comes from the registered count, so a push is never offered
  // against a full queue even if the engine pops on the same edge.
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;

  gcd_fifo #(
    .WIDTH2 (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({in_a, in_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_a    = head[2*WIDTH-1:WIDTH];
  assign head_b    = head[WIDTH-1:0];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign both_even = !x_q[0] && !y_q[0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A zero operand needs no iterations and goes straight to OUT.
        if (!fifo_empty) state_d = head_zero ? OUT : COMMON;
      end
      COMMON: begin
        if (!both_even) state_d = REDUCE;
      end
      REDUCE: begin
        if (y_q == '0) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Popping only from IDLE means the release edge out of OUT never pops; the
  // next pair is taken one edge later.
  always_comb begin
    pop       = (state_q == IDLE) && !fifo_empty;
    out_valid = (state_q == OUT);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    k_d   = k_q;
    res_d = res_q;
    a_d   = a_q;
    b_d   = b_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          a_d   = head_a;
          b_d   = head_b;
          cyc_d = '0;
          if (head_zero) begin
            // gcd(0,n) = n and gcd(0,0) = 0; both reduce to an OR.
            res_d = head_a | head_b;
          end else begin
            x_d = head_a;
            y_d = head_b;
            k_d = '0;
          end
        end
      end
      COMMON: begin
        cyc_d = cyc_q + CW'(1);
        // Strip the shared power of two, remembered in k.
        if (both_even) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end
      end
      REDUCE: begin
        cyc_d = cyc_q + CW'(1);
        // Rule order matters: both values are odd by the time we subtract,
        // and the larger one is always the minuend, so no underflow.
        if (y_q == '0) begin
          res_d = x_q << k_q;
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          x_d = y_q;
          y_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: ; // OUT holds every output register
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      k_q   <= '0;
      res_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cyc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      k_q   <= k_d;
      res_q <= res_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cyc_q <= cyc_d;
    end
  end

  assign out_result = res_q;
  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_cycles = cyc_q;

endmodule

// File: tb/tb_gcd_stream.sv
module tb_gcd_stream;
  import gcd_pkg::*;

  localparam int CW32 = cycle_w(32);
  localparam int CW8  = cycle_w(8);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit / depth-4 instance
  logic            v32 = 1'b0, rdy32, ov32, ordy32 = 1'b0;
  logic [31:0]     a32 = '0, b32 = '0, res32, oa32, ob32;
  logic [CW32-1:0] cyc32;

  // 8-bit / depth-2 instance
  logic           v8 = 1'b0, rdy8, ov8, ordy8 = 1'b0;
  logic [7:0]     a8 = '0, b8 = '0, res8, oa8, ob8;
  logic [CW8-1:0] cyc8;

  gcd_stream #(.WIDTH(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
    .out_valid(ov32), .out_ready(ordy32), .out_result(res32), .out_a(oa32), .out_b(ob32),
    .out_cycles(cyc32));

  gcd_stream #(.WIDTH(8), .DEPTH(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_a(oa8), .out_b(ob8),
    .out_cycles(cyc8));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: Euclid by remainder, a different algorithm from the DUT's.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p, q, t;
    p = a; q = b;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic push32(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    v32 = 1'b1; a32 = a; b32 = b;
    while (!rdy32 && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL push32_timeout in_ready=%0b required 1", rdy32); end
    @(negedge clk);
    v32 = 1'b0;
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    v8 = 1'b1; a8 = a; b8 = b;
    while (!rdy8 && t < 500) begin @(negedge clk); t++; end
    n_checks++;
    if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL push8_timeout in_ready=%0b required 1", rdy8); end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  // n = edges passed until out_valid is seen.
  task automatic wait32(output int n);
    n = 0;
    while (!ov32 && n < MAX_CYCLES(32) + 20) begin @(negedge clk); n++; end
    n_checks++;
    if (ov32 !== 1'b1) begin n_fail++; $display("FAIL wait32_timeout out_valid=%0b required 1", ov32); end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (!ov8 && n < 300) begin @(negedge clk); n++; end
    n_checks++;
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL wait8_timeout out_valid=%0b required 1", ov8); end
  endtask

  task automatic consume32();
    ordy32 = 1'b1; @(negedge clk); ordy32 = 1'b0;
  endtask

  task automatic consume8();
    ordy8 = 1'b1; @(negedge clk); ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", rdy32); end
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", ov32); end
    n_checks++;
    if ({res32, oa32, ob32} !== 96'd0 || cyc32 !== '0) begin
      n_fail++; $display("FAIL rst_outputs got %h %h %h %0d want zeros", res32, oa32, ob32, cyc32);
    end
    n_checks++; if (rdy8 !== 1'b0 || ov8 !== 1'b0) begin n_fail++; $display("FAIL rst_dut8 got rdy=%0b vld=%0b want 0 0", rdy8, ov8); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %0b want 1", rdy32); end
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rst_release_out_valid got %0b want 0", ov32); end
  endtask

  task automatic test_basic();
    int n;
    push32(32'd48, 32'd18);
    wait32(n);
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL basic_latency got %0d edges want 10", n); end
    n_checks++; if (res32 !== 32'd6) begin n_fail++; $display("FAIL basic_result got %0d want 6", res32); end
    n_checks++; if (cyc32 !== CW32'(9)) begin n_fail++; $display("FAIL basic_cycles got %0d want 9", cyc32); end
    n_checks++; if (oa32 !== 32'd48 || ob32 !== 32'd18) begin n_fail++; $display("FAIL basic_echo got %0d,%0d want 48,18", oa32, ob32); end
    consume32();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL basic_release got %0b want 0", ov32); end
  endtask

  task automatic test_zero();
    logic [31:0] za [3] = '{32'd0, 32'd0, 32'd9};
    logic [31:0] zb [3] = '{32'd0, 32'd7, 32'd0};
    logic [31:0] zr [3] = '{32'd0, 32'd7, 32'd9};
    int n;
    for (int i = 0; i < 3; i++) begin
      push32(za[i], zb[i]);
      wait32(n);
      n_checks++; if (n != 1) begin n_fail++; $display("FAIL zero_latency[%0d] got %0d want 1", i, n); end
      n_checks++; if (res32 !== zr[i]) begin n_fail++; $display("FAIL zero_result[%0d] got %0d want %0d", i, res32, zr[i]); end
      n_checks++; if (cyc32 !== '0) begin n_fail++; $display("FAIL zero_cycles[%0d] got %0d want 0", i, cyc32); end
      consume32();
    end
  endtask

  task automatic test_msb();
    int n;
    push32(32'h8000_0000, 32'hC000_0000);
    wait32(n);
    n_checks++; if (res32 !== 32'h4000_0000) begin n_fail++; $display("FAIL msb_result got %h want 40000000", res32); end
    n_checks++; if (int'(cyc32) > MAX_CYCLES(32)) begin n_fail++; $display("FAIL msb_cycles got %0d want <= %0d", cyc32, MAX_CYCLES(32)); end
    consume32();
    push32(32'd17, 32'd17);
    wait32(n);
    n_checks++; if (res32 !== 32'd17) begin n_fail++; $display("FAIL equal_result got %0d want 17", res32); end
    n_checks++; if (cyc32 !== CW32'(3)) begin n_fail++; $display("FAIL equal_cycles got %0d want 3", cyc32); end
    consume32();
  endtask

  task automatic test_stall();
    ordy32 = 1'b0;
    for (int i = 3; i <= 7; i++) push32(32'(i), 32'(2 * i));
    n_checks++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL stall_full in_ready got %0b want 0", rdy32); end
    fork
      push32(32'd8, 32'd16);
      begin
        int n;
        logic [31:0] r, oa, ob;
        logic [CW32-1:0] cy;
        logic stable;
        for (int i = 3; i <= 8; i++) begin
          wait32(n);
          r = res32; oa = oa32; ob = ob32; cy = cyc32;
          n_checks++; if (r !== 32'(i)) begin n_fail++; $display("FAIL stall_result[%0d] got %0d want %0d", i, r, i); end
          n_checks++; if (oa !== 32'(i) || ob !== 32'(2 * i)) begin n_fail++; $display("FAIL stall_echo[%0d] got %0d,%0d want %0d,%0d", i, oa, ob, i, 2 * i); end
          stable = 1'b1;
          repeat (3) begin
            @(negedge clk);
            if (!ov32 || res32 !== r || oa32 !== oa || ob32 !== ob || cyc32 !== cy) stable = 1'b0;
          end
          n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] outputs changed while stalled got %0b want 1", i, stable); end
          consume32();
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    push32(32'd1, 32'hFFFF_FFFF);   // long REDUCE phase
    push32(32'd5, 32'd10);
    push32(32'd7, 32'd21);
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy out_valid got %0b want 0", ov32); end
    rst = 1'b1;
    #1;
    n_checks++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %0b want 0", rdy32); end
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %0b want 0", ov32); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (200) begin @(negedge clk); if (ov32) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale result appeared got %0b want 0", seen); end
    push32(32'd12, 32'd8);
    wait32(n);
    n_checks++; if (res32 !== 32'd4) begin n_fail++; $display("FAIL midrst_new_result got %0d want 4", res32); end
    n_checks++; if (oa32 !== 32'd12 || ob32 !== 32'd8) begin n_fail++; $display("FAIL midrst_new_echo got %0d,%0d want 12,8", oa32, ob32); end
    consume32();
  endtask

  task automatic test_random8();
    logic [15:0] sb[$];
    fork
      begin
        logic [7:0] a, b;
        for (int i = 0; i < 500; i++) begin
          a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
          b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
          sb.push_back({a, b});
          push8(a, b);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
      begin
        int n;
        logic [15:0] e;
        logic [31:0] g;
        for (int i = 0; i < 500; i++) begin
          wait8(n);
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++; $display("FAIL rand_unexpected result %0d with empty scoreboard want none", res8);
          end else begin
            e = sb.pop_front();
            g = ref_gcd({24'd0, e[15:8]}, {24'd0, e[7:0]});
            if (oa8 !== e[15:8] || ob8 !== e[7:0]) begin
              n_fail++; $display("FAIL rand_echo[%0d] got %0d,%0d want %0d,%0d", i, oa8, ob8, e[15:8], e[7:0]);
            end
            n_checks++;
            if (res8 !== g[7:0]) begin
              n_fail++; $display("FAIL rand_result[%0d] gcd(%0d,%0d) got %0d want %0d", i, e[15:8], e[7:0], res8, g[7:0]);
            end
            n_checks++;
            if (int'(cyc8) > MAX_CYCLES(8)) begin
              n_fail++; $display("FAIL rand_cycles_max[%0d] got %0d want <= %0d", i, cyc8, MAX_CYCLES(8));
            end
            n_checks++;
            if (e[15:8] == 0 || e[7:0] == 0) begin
              if (cyc8 !== '0) begin n_fail++; $display("FAIL rand_cycles_zero[%0d] got %0d want 0", i, cyc8); end
            end else if (int'(cyc8) < 2) begin
              n_fail++; $display("FAIL rand_cycles_min[%0d] got %0d want >= 2", i, cyc8);
            end
          end
          repeat ($urandom_range(0, 2)) @(negedge clk);
          consume8();
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_msb();
    test_stall();
    test_reset_mid();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
